// File: rtl/phase_sequencer_if.sv
// Phase sequencer bus: board-side controls in, phase enables and status out.
//   exec     : raw Exec button level (asynchronous to clk)
//   mode     : 00 run, 01 instruction step, 10 phase step, 11 reserved
//   halt     : halt request from the control decoder
//   p        : one-hot phase enable, p[0] is the fetch phase
//   busy     : high while phases are being issued
//   halted   : sticky halt status
//   inst_cnt : completed instruction count
// master drives the controls (board / bench), slave is the sequencer.
interface phase_sequencer_if #(
    parameter int unsigned NPHASE = 5,
    parameter int unsigned CNT_W  = 16
);
    logic              exec;
    logic [1:0]        mode;
    logic              halt;
    logic [NPHASE-1:0] p;
    logic              busy;
    logic              halted;
    logic [CNT_W-1:0]  inst_cnt;

    modport master (
        output exec, mode, halt,
        input  p, busy, halted, inst_cnt
    );

    modport slave (
        input  exec, mode, halt,
        output p, busy, halted, inst_cnt
    );
endinterface

// File: rtl/phase_sequencer.sv
// Multi-cycle datapath phase sequencer with debounced Exec button, run /
// instruction-step / phase-step modes, sticky halt and an instruction counter.
// Ports:
//   clk : system clock
//   rst : synchronous active-high reset; aborts any instruction in flight
//   sq  : phase_sequencer_if slave (exec, mode, halt in; p, busy, halted, inst_cnt out)
module phase_sequencer #(
    parameter int unsigned NPHASE   = 5,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned DEBOUNCE = 16
) (
    input logic               clk,
    input logic               rst,
    phase_sequencer_if.slave  sq
);
    localparam int unsigned PH_W   = $clog2(NPHASE);
    localparam int unsigned DB_W   = $clog2(DEBOUNCE + 1);
    localparam int unsigned STEP_W = $clog2(NPHASE + 1);

    typedef enum logic [2:0] {StIdle, StRun, StStepI, StStepP, StHalted} state_e;

    // Input conditioning
    logic            r_s1, r_s2, r_db, r_db_prev;
    logic [DB_W-1:0] r_db_cnt;
    logic            w_exec_pulse;

    // Sequencer state
    state_e            r_state, w_state_d;
    logic [PH_W-1:0]   r_ph;
    logic              r_pause, w_pause_d;
    logic [STEP_W-1:0] r_step_cnt, w_step_cnt_d;
    logic [CNT_W-1:0]  r_inst_cnt;
    logic              w_busy;
    logic              w_last;

    // Two-flop synchroniser followed by a stable-level debouncer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_db      <= 1'b0;
            r_db_prev <= 1'b0;
            r_db_cnt  <= '0;
        end else begin
            r_s1      <= sq.exec;
            r_s2      <= r_s1;
            r_db_prev <= r_db;
            if (r_s2 == r_db) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_W'(DEBOUNCE - 1)) begin
                // s2 has now differed for DEBOUNCE consecutive cycles
                r_db     <= r_s2;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    assign w_exec_pulse = r_db & ~r_db_prev;
    assign w_last       = (r_ph == PH_W'(NPHASE - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StIdle;
            r_ph       <= '0;
            r_pause    <= 1'b0;
            r_step_cnt <= '0;
            r_inst_cnt <= '0;
        end else begin
            r_state    <= w_state_d;
            r_pause    <= w_pause_d;
            r_step_cnt <= w_step_cnt_d;
            if (w_busy) begin
                if (w_last) begin
                    r_ph       <= '0;
                    r_inst_cnt <= r_inst_cnt + 1'b1;
                end else begin
                    r_ph <= r_ph + 1'b1;
                end
            end
        end
    end

    // Next-state logic; halt at the last phase outranks pause and step completion.
    always_comb begin
        w_state_d    = r_state;
        w_pause_d    = r_pause;
        w_step_cnt_d = r_step_cnt;
        unique case (r_state)
            StIdle: begin
                if (w_exec_pulse) begin
                    w_pause_d    = 1'b0;
                    w_step_cnt_d = '0;
                    case (sq.mode)
                        2'b00:   w_state_d = StRun;
                        2'b01:   w_state_d = StStepI;
                        2'b10:   w_state_d = StStepP;
                        default: w_state_d = StIdle;
                    endcase
                end
            end
            StRun: begin
                if (w_last && sq.halt) begin
                    w_state_d = StHalted;
                end else if (w_last && (r_pause || w_exec_pulse)) begin
                    w_state_d = StIdle;
                    w_pause_d = 1'b0;
                end else if (w_exec_pulse) begin
                    w_pause_d = 1'b1;
                end
            end
            StStepI: begin
                if (w_last && sq.halt) begin
                    w_state_d = StHalted;
                end else if (r_step_cnt == STEP_W'(NPHASE - 1)) begin
                    w_state_d = StIdle;
                end else begin
                    w_step_cnt_d = r_step_cnt + 1'b1;
                end
            end
            StStepP: begin
                // ph is kept so the next step resumes mid-instruction
                if (w_last && sq.halt) begin
                    w_state_d = StHalted;
                end else begin
                    w_state_d = StIdle;
                end
            end
            StHalted: w_state_d = StHalted;
            default:  w_state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        w_busy      = (r_state == StRun) || (r_state == StStepI) || (r_state == StStepP);
        sq.p        = w_busy ? (NPHASE'(1) << r_ph) : '0;
        sq.busy     = w_busy;
        sq.halted   = (r_state == StHalted);
        sq.inst_cnt = r_inst_cnt;
    end
endmodule
